ps2_frame_receiver: RTL and testbench
=====================================

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8, is the number of consecutive equal synchronised ps2_clk samples needed to change the filtered clock level; legal range 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, is the idle clk cycles allowed between two filtered falling edges inside a frame; minimum 16.
REQ-003 clk  input  1  single clock for all logic; write-side clock of the downstream asynchronous FIFO.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock pin, asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data pin, asynchronous to clk.
REQ-007 fifo_full  input  1  full flag from the downstream FIFO write side.
REQ-008 data_out  output  8  last accepted scan-code byte, driven to the FIFO data input.
REQ-009 w_en  output  1  one-cycle write strobe to the FIFO.
REQ-010 parity_err  output  1  one-cycle pulse: frame dropped on an odd-parity failure.
REQ-011 frame_err  output  1  one-cycle pulse: frame dropped on a bad stop bit or a timeout.
REQ-012 overflow  output  1  one-cycle pulse: valid frame dropped because fifo_full was high.
REQ-013 busy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser before any other use.
REQ-015 Filter: the filtered clock SHALL go to 1 when the last FILTER_LEN synchronised ps2_clk samples are all 1, go to 0 when they are all 0, and otherwise hold its value.
REQ-016 A sample event SHALL be the single clk cycle in which the filtered clock changes from 1 to 0; the synchronised ps2_data value in that cycle is the sampled bit.
REQ-017 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-018 IDLE: a sampled 0 (start bit) SHALL move the FSM to DATA with the bit counter at 0; a sampled 1 SHALL be ignored.
REQ-019 DATA: each sample SHALL shift into an 8-bit register LSB-first; after the 8th sample the FSM SHALL move to PARITY.
REQ-020 PARITY: the sample SHALL be stored and the FSM SHALL move to STOP.
REQ-021 STOP: the sample SHALL end the frame and the FSM SHALL return to IDLE.
REQ-022 Parity is OK when the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
REQ-023 STOP outcome, in priority order, registered in the cycle after the stop sample:
- stop bit = 0: frame_err pulses.
- parity fails: parity_err pulses.
- fifo_full = 1 in the stop-sample cycle: overflow pulses.
- otherwise: w_en pulses and data_out is loaded with the byte.
REQ-024 Exactly one of w_en, parity_err, frame_err and overflow SHALL pulse per completed frame, each for exactly 1 cycle.
REQ-025 data_out SHALL change only together with w_en and SHALL otherwise hold the last accepted byte.
REQ-026 Timeout timer: the timer SHALL clear on every sample event and in IDLE, and SHALL count otherwise.
REQ-027 Timeout action: if the timer reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL return to IDLE, frame_err SHALL pulse once and no w_en SHALL be issued.
REQ-028 Timer width SHALL be $clog2(TIMEOUT_CYCLES) bits and the timer SHALL never wrap.
REQ-029 A sample event in the same cycle as a timeout SHALL be ignored.
REQ-030 A new start bit SHALL be accepted on the first sample event after the FSM returns to IDLE; no gap cycles are required.
REQ-031 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-032 While rst is high: FSM = IDLE, bit counter = 0, shift register = 0, timer = 0, synchronisers = 1, filter history = 1, filtered clock = 1.
REQ-033 While rst is high: data_out = 0x00, and w_en, parity_err, frame_err, overflow and busy = 0.
REQ-034 rst asserted mid-frame SHALL discard the partial frame with no pulse on any output.
REQ-035 After rst is released, the first frame SHALL be received normally.

Verification
REQ-036 Frame bits 0,0,0,1,1,1,0,0,0,0,1 (byte 0x1C, parity 0, stop 1), fifo_full=0 -> one w_en pulse, data_out=0x1C, no error pulses, busy low after the stop sample.
REQ-037 Same frame with the parity bit set to 1 -> one parity_err pulse, no w_en, data_out keeps its previous value.
REQ-038 Byte 0xF0 with stop bit 0 -> one frame_err pulse; a following valid 0xF0 frame -> w_en pulse, data_out=0xF0.
REQ-039 Valid 0x1C frame with fifo_full=1 -> one overflow pulse, no w_en.
REQ-040 Start bit plus 4 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES-1 cycles after the last sample, busy drops; a following valid frame is received correctly.
REQ-041 ps2_clk low glitch lasting FILTER_LEN-1 clk cycles -> no sample event and busy stays 0.
REQ-042 rst pulsed after the 5th bit of a frame -> all outputs at reset values with no pulses; a following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB-first,
//   odd parity, stop) and hands accepted scan codes to the write side of a
//   downstream FIFO.
//
//   Parameters
//     FILTER_LEN     : consecutive equal synchronised ps2_clk samples needed
//                      to change the filtered clock level (2..16)
//     TIMEOUT_CYCLES : idle clk cycles allowed between two filtered falling
//                      edges inside a frame (>= 16)
//
//   Ports
//     clk        in   system clock, also the FIFO write clock
//     rst        in   asynchronous active-high reset
//     ps2_clk    in   PS/2 clock pin (asynchronous)
//     ps2_data   in   PS/2 data pin (asynchronous)
//     fifo_full  in   FIFO full flag
//     data_out   out  last accepted byte
//     w_en       out  one-cycle FIFO write strobe
//     parity_err out  one-cycle pulse, frame dropped on parity failure
//     frame_err  out  one-cycle pulse, frame dropped on bad stop bit/timeout
//     overflow   out  one-cycle pulse, valid frame dropped on fifo_full
//     busy       out  high while a frame is in progress
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       w_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchronisers: bit 1 is the synchronised value.
  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [7:0]            data_out_q, data_out_d;
  logic                  w_en_q, w_en_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;

  logic                  sample_evt;
  logic                  sample_bit;
  logic                  timeout;

  // ---------------------------------------------------------------------
  // Synchronisation and glitch filter
  // ---------------------------------------------------------------------
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    hist_d      = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_d      = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end
  end

  // The event is the cycle in which the filtered level is about to drop,
  // so the data sampled alongside it is the synchronised bit of that cycle.
  assign sample_evt = filt_q & ~filt_d;
  assign sample_bit = data_sync_q[1];

  // ---------------------------------------------------------------------
  // Inter-edge timeout
  // ---------------------------------------------------------------------
  assign timeout = (state_q != IDLE) && (timer_q == TIMER_MAX);

  always_comb begin
    timer_d = timer_q;
    if ((state_q == IDLE) || sample_evt) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      // Saturate rather than wrap; a timeout returns to IDLE next cycle
      // which clears the timer anyway.
      timer_d = timer_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM and registered outcome pulses
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    data_out_d   = data_out_q;
    w_en_d       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overflow_d   = 1'b0;

    if (timeout) begin
      // A sample coinciding with the timeout is deliberately dropped.
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (sample_evt) begin
      case (state_q)
        IDLE: begin
          if (!sample_bit) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = sample_bit;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!sample_bit) begin
            frame_err_d = 1'b1;
          end else if ((^shift_q ^ parity_q) != 1'b1) begin
            parity_err_d = 1'b1;
          end else if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            w_en_d     = 1'b1;
            data_out_d = shift_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      hist_q       <= '1;
      filt_q       <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      data_out_q   <= 8'h00;
      w_en_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      hist_q       <= hist_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      w_en_q       <= w_en_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign data_out   = data_out_q;
  assign w_en       = w_en_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed frames, a timeout,
// a filter glitch, a mid-frame reset and a run of random frames checked
// against a frame-level outcome model.
module tb_ps2_frame_receiver;

  localparam int F    = 8;
  localparam int T    = 40;
  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] data_out;
  logic       w_en, parity_err, frame_err, overflow, busy;

  int checks = 0;
  int failures = 0;

  // Pulse counters and protocol watchers, sampled on the falling clk edge.
  int wen_cnt = 0, perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  int width_err = 0, dchg_err = 0;
  logic       p_wen = 0, p_perr = 0, p_ferr = 0, p_ovf = 0;
  logic [7:0] p_dout = 8'h00;

  logic [7:0] exp_dout = 8'h00;

  ps2_frame_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .fifo_full(fifo_full), .data_out(data_out), .w_en(w_en),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) wen_cnt++;
      if (parity_err) perr_cnt++;
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if ((w_en && p_wen) || (parity_err && p_perr) ||
          (frame_err && p_ferr) || (overflow && p_ovf)) width_err++;
      if ((data_out !== p_dout) && !w_en) dchg_err++;
    end
    p_wen = w_en; p_perr = parity_err; p_ferr = frame_err; p_ovf = overflow;
    p_dout = data_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a full low/high period.
  task automatic send_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] byte_v, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
    send_bit(par);
    send_bit(stop);
    @(negedge clk); ps2_data = 1'b1;
  endtask

  // Outcome codes: 0 = w_en, 1 = parity_err, 2 = frame_err, 3 = overflow.
  function automatic int model_outcome(input logic [7:0] b, input logic par,
                                       input logic stop, input logic full);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    ones += par;
    if (!stop) return 2;
    if (ones % 2 != 1) return 1;
    if (full) return 3;
    return 0;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                           input logic stop, input logic full);
    int w0, p0, f0, o0, oc;
    w0 = wen_cnt; p0 = perr_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
    oc = model_outcome(b, par, stop, full);
    if (oc == 0) exp_dout = b;
    fifo_full = full;
    send_frame(b, par, stop);
    repeat (20) @(negedge clk);
    fifo_full = 1'b0;
    chk({tag, ".w_en"},       wen_cnt - w0,  (oc == 0) ? 1 : 0);
    chk({tag, ".parity_err"}, perr_cnt - p0, (oc == 1) ? 1 : 0);
    chk({tag, ".frame_err"},  ferr_cnt - f0, (oc == 2) ? 1 : 0);
    chk({tag, ".overflow"},   ovf_cnt - o0,  (oc == 3) ? 1 : 0);
    chk({tag, ".data_out"},   data_out, exp_dout);
    chk({tag, ".busy"},       busy, 1'b0);
    $display("frame %s byte=%02h par=%0b stop=%0b full=%0b outcome=%0d data_out=%02h",
             tag, b, par, stop, full, oc, data_out);
  endtask

  initial begin
    int lat, fe, w0, f0, bh;
    logic [7:0] rb;
    logic rp, rs, rf;

    // Reset state.
    repeat (4) @(negedge clk);
    chk("reset.data_out", data_out, 8'h00);
    chk("reset.pulses", {w_en, parity_err, frame_err, overflow}, 4'b0000);
    chk("reset.busy", busy, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Directed frames.
    run_frame("valid_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    run_frame("par_bad_1c", 8'h1C, 1'b1, 1'b1, 1'b0);
    run_frame("stop_bad_f0", 8'hF0, 1'b1, 1'b0, 1'b0);
    run_frame("valid_f0", 8'hF0, 1'b1, 1'b1, 1'b0);
    run_frame("full_1c", 8'h1C, 1'b0, 1'b1, 1'b1);

    // Timeout: start + 4 data bits, then ps2_clk held high.
    w0 = wen_cnt; f0 = ferr_cnt; lat = 0; fe = 0;
    @(negedge clk); ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    @(posedge clk); #1 ps2_clk = 1'b0;
    for (int n = 1; n <= HALF; n++) begin
      @(posedge clk); #1;
      if (busy && lat == 0) lat = n;
      if (n == HALF) ps2_clk = 1'b1;
    end
    chk("timeout.start_latency_ok", (lat > 0 && lat < HALF) ? 1 : 0, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    @(posedge clk); #1 ps2_clk = 1'b0;
    for (int n = 1; n <= lat + T + 20; n++) begin
      @(posedge clk); #1;
      if (frame_err && fe == 0) fe = n;
      if (n == HALF) ps2_clk = 1'b1;
    end
    // The timer sits at 0 after the sample update, reaches T-1 after T-1
    // further cycles, and the registered frame_err appears one edge later.
    chk("timeout.frame_err_edge", fe, lat + T);
    chk("timeout.frame_err_count", ferr_cnt - f0, 1);
    chk("timeout.no_w_en", wen_cnt - w0, 0);
    chk("timeout.busy", busy, 1'b0);
    $display("timeout start_latency=%0d frame_err_edge=%0d", lat, fe);
    run_frame("after_timeout", 8'h5A, odd_par(8'h5A), 1'b1, 1'b0);

    // Glitch shorter than the filter on an idle line with data low.
    bh = 0;
    @(negedge clk); ps2_data = 1'b0;
    @(posedge clk); #1 ps2_clk = 1'b0;
    repeat (F - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) bh++;
    end
    ps2_data = 1'b1;
    chk("glitch.busy_cycles", bh, 0);
    $display("glitch busy_cycles=%0d", bh);

    // Reset after the 5th bit of a frame.
    w0 = wen_cnt; f0 = ferr_cnt + perr_cnt + ovf_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("midreset.busy_before", busy, 1'b1);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset.data_out", data_out, 8'h00);
    chk("midreset.pulses", {w_en, parity_err, frame_err, overflow}, 4'b0000);
    chk("midreset.busy", busy, 1'b0);
    rst = 1'b0; exp_dout = 8'h00; ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    chk("midreset.no_pulses", (wen_cnt - w0) + (ferr_cnt + perr_cnt + ovf_cnt - f0), 0);
    $display("midreset data_out=%02h busy=%0b", data_out, busy);
    run_frame("after_reset_1c", 8'h1C, 1'b0, 1'b1, 1'b0);

    // Random frames against the outcome model.
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      rp = odd_par(rb) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 7) != 0);
      rf = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rand%0d", k), rb, rp, rs, rf);
    end

    chk("pulse_width_violations", width_err, 0);
    chk("data_out_change_without_w_en", dchg_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
